// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries LANES payload slots across one stage boundary and applies the core
// stall vector (hold / bubble / advance). Each lane can be flushed on its own.
// Saturating counters record bubble cycles and flush cycles for perf debug.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter int                LANES     = 1,
    parameter int                STALL_W   = 6,
    parameter int                STAGE     = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CNT_W     = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [STALL_W-1:0]      stall_in,
    input  logic [LANES-1:0]        flush_in,
    input  logic [LANES-1:0]        valid_in,
    input  logic [LANES*DATA_W-1:0] data_in,
    output logic [LANES-1:0]        valid_out,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]        bubble_cnt_out,
    output logic [CNT_W-1:0]        flush_cnt_out
);

    // Reject parameter combinations that would index outside the stall vector
    generate
        if (LANES < 1) begin : g_bad_lanes
            $error("pipe_stage_reg: LANES must be at least 1");
        end
        if (STAGE < 0 || STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE+1 must be a valid index into stall_in");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic up;
    logic dn;
    logic bubble_cycle;
    logic flush_cycle;

    assign up           = stall_in[STAGE];
    assign dn           = stall_in[STAGE+1];
    assign bubble_cycle = up & ~dn;
    assign flush_cycle  = |flush_in;

    // Per-lane update: reset, then flush, bubble, advance; otherwise hold.
    // Up=0 with dn=1 cannot come from the stall unit and simply advances.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_out <= '0;
            for (int i = 0; i < LANES; i++) begin
                data_out[i*DATA_W +: DATA_W] <= NOP_VALUE;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (flush_in[i] || bubble_cycle) begin
                    valid_out[i]                 <= 1'b0;
                    data_out[i*DATA_W +: DATA_W] <= NOP_VALUE;
                end else if (!up) begin
                    valid_out[i]                 <= valid_in[i];
                    data_out[i*DATA_W +: DATA_W] <= data_in[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Saturating event counters, one count per cycle regardless of lane count
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bubble_cnt_out <= '0;
            flush_cnt_out  <= '0;
        end else begin
            if (bubble_cycle && bubble_cnt_out != CNT_MAX) begin
                bubble_cnt_out <= bubble_cnt_out + CNT_ONE;
            end
            if (flush_cycle && flush_cnt_out != CNT_MAX) begin
                flush_cnt_out <= flush_cnt_out + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core, the generalised successor to the fixed ID/EX latch. It carries an opaque payload across one stage boundary for `LANES` parallel issue slots. It applies the core's stall-vector convention (hold, bubble, advance), adds per-lane flush and per-lane valid bits, and keeps saturating bubble and flush event counters for performance debug. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), selected by `STAGE`.

## Interface
- `DATA_W`, default 64: payload width per lane.
- `LANES`, default 1: number of parallel lanes; must be ≥ 1.
- `STALL_W`, default 6: width of the core stall vector.
- `STAGE`, default 2: stall-vector index of the upstream stage. `STAGE+1` must be < `STALL_W`; any other value is an elaboration error.
- `NOP_VALUE`, default 0: `DATA_W`-bit payload written into a lane when it is emptied.
- `CNT_W`, default 16: width of each event counter.

- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-low (0 = reset).
- `stall_in`  in  `STALL_W`  core stall vector; 1 = stall.
- `flush_in`  in  `LANES`  per-lane flush request, level-sampled at the clock edge.
- `valid_in`  in  `LANES`  per-lane valid from the upstream stage.
- `data_in`  in  `LANES*DATA_W`  payload; lane *i* occupies bits [i*DATA_W +: DATA_W].
- `valid_out`  out  `LANES`  registered per-lane valid to the downstream stage.
- `data_out`  out  `LANES*DATA_W`  registered payload, same packing as `data_in`.
- `bubble_cnt_out`  out  `CNT_W`  number of bubble-insert cycles, saturating.
- `flush_cnt_out`  out  `CNT_W`  number of cycles with any lane flushed, saturating.

## Operation
- Define `up` = `stall_in[STAGE]` and `dn` = `stall_in[STAGE+1]`.
- Each lane independently resolves one action per cycle. Priority, highest first:
  1. **Reset** (`rst_in`=0): `valid_out`=0, `data_out`=`NOP_VALUE` in every lane, both counters = 0.
  2. **Flush** (`flush_in[i]`=1): lane *i* gets `valid_out[i]`=0 and payload `NOP_VALUE`. This applies regardless of `up`/`dn`, so a flush overrides a hold.
  3. **Bubble** (`up`=1, `dn`=0): lane gets `valid_out`=0 and payload `NOP_VALUE`.
  4. **Advance** (`up`=0): lane loads `valid_in[i]` and `data_in` for lane *i*.
  5. **Hold** (`up`=1, `dn`=1): lane keeps its current `valid_out` and `data_out`.
- `up`=0 with `dn`=1 is an illegal stall vector, because the stall unit always stalls every earlier stage. The block treats it as Advance and does not check for it.
- A lane loaded with `valid_in[i]`=0 still captures the `data_in` payload. Downstream logic must qualify the payload with `valid_out`.
- `bubble_cnt_out` increments by 1 in each cycle where `up`=1 and `dn`=0. The cycle is counted once, not once per lane. It is counted even if every lane is also flushed.
- `flush_cnt_out` increments by 1 in each cycle where `flush_in` is non-zero. The cycle is counted once, not once per lane.
- Both counters saturate at 2^`CNT_W`−1 and never wrap.
- Bits of `stall_in` other than `STAGE` and `STAGE+1` are ignored.

## Timing
- All outputs are registered; there is no combinational path from input to output. Latency is one cycle.
- Reset takes effect at the first rising edge with `rst_in`=0.
- Reset asserted mid-hold or mid-flush discards all held state at that edge.
- The first Advance can occur at the first edge with `rst_in`=1.
- A hold lasts exactly as long as `up`=`dn`=1; there is no timeout.
- A single-cycle `flush_in` pulse empties the lane at that edge. A flush held for N cycles keeps the lane empty for N cycles and adds N to `flush_cnt_out`.
- Counter updates take effect on the same edge as the lane update for that cycle.

## Test plan
- **Reset:** hold `rst_in`=0 for 2 cycles with `valid_in`=all-1 and `data_in`=0xDEAD_BEEF… → `valid_out`=0, `data_out`=`NOP_VALUE`, both counters 0.
- **Advance and hold:** `STAGE`=2, `LANES`=2. Drive lane0=0x11 and lane1=0x22 with valid=2'b11 and stall=0 → outputs show 0x11/0x22 one cycle later. Then set stall[2]=stall[3]=1 for 3 cycles while inputs change to 0x33/0x44 → outputs stay 0x11/0x22 and valid stays 2'b11 for those 3 cycles.
- **Bubble:** with stall[2]=1 and stall[3]=0 for 2 cycles → `valid_out`=2'b00, `data_out`=`NOP_VALUE`, `bubble_cnt_out`=2.
- **Flush over hold:** hold active, pulse `flush_in`=2'b10 for 1 cycle → lane1 becomes invalid with payload `NOP_VALUE`, lane0 is still held with its payload, `flush_cnt_out`=1.
- **Saturation:** `CNT_W`=4, drive 20 consecutive bubble cycles → `bubble_cnt_out` stops at 15.
- **Ignored bits:** toggle stall[0] and stall[5] randomly while stall[2]=stall[3]=0 → every cycle Advances; outputs track inputs with one-cycle delay.
